y86_mem_port: RTL and testbench

Client-side sequencer that drives the SRAM controller's request interface (READ/WRITE strobes, addresses, byte lanes, write data) and consumes its 16-bit read data. It turns Y86 CPU byte-addressed byte/long loads and stores into a sequence of 16-bit SRAM phases, including unaligned longs, and returns a 32-bit result with a single-cycle DONE handshake. It sits between the Y86 fetch/memory stages and the SRAM controller.

---
 rtl/y86_mem_port.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_y86_mem_port.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_mem_port.sv
// Y86 client-side SRAM sequencer: splits byte/long loads and stores into 16-bit SRAM phases.
// Optional `MEM_PORT_ALIGN_CHECK_EN adds ERR and rejects unaligned longs instead of splitting them.
module y86_mem_port #(
    parameter int ACC_CYCLES = 2
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        REQ,
    input  logic        WE,
    input  logic        SIZE,
    input  logic [18:0] ADDR,
    input  logic [31:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RDATA,
    output logic        READ,
    output logic        WRITE,
    output logic [17:0] ADDRESS_R,
    output logic [17:0] ADDRESS_W,
    output logic [15:0] VALUE_W,
    output logic        LB,
    output logic        HB,
`ifdef MEM_PORT_ALIGN_CHECK_EN
    output logic        ERR,
`endif
    input  logic [15:0] VALUE
);

    typedef enum logic [1:0] {IDLE, ACCESS, GAP} state_t;

    localparam logic [3:0] CNT_LAST = 4'(ACC_CYCLES - 1);

    // Store lane mapping for one phase, packed as {lb, hb, value}.
    function automatic logic [17:0] lanes(input logic size, input logic a0,
                                          input logic [1:0] ph, input logic [31:0] d);
        logic [17:0] r;
        r = '0;
        if (!size) begin
            r = a0 ? {2'b01, d[7:0], 8'h00} : {2'b10, 8'h00, d[7:0]};
        end else if (!a0) begin
            r = (ph == 2'd0) ? {2'b11, d[15:0]} : {2'b11, d[31:16]};
        end else begin
            case (ph)
                2'd0:    r = {2'b01, d[7:0], 8'h00};
                2'd1:    r = {2'b11, d[23:8]};
                default: r = {2'b10, 8'h00, d[31:24]};
            endcase
        end
        return r;
    endfunction

    // Load assembly: the inverse of the store lane mapping.
    function automatic logic [31:0] merge(input logic [31:0] acc, input logic size, input logic a0,
                                          input logic [1:0] ph, input logic [15:0] v);
        logic [31:0] r;
        r = acc;
        if (!size) begin
            r[7:0] = a0 ? v[15:8] : v[7:0];
        end else if (!a0) begin
            if (ph == 2'd0) r[15:0] = v;
            else            r[31:16] = v;
        end else begin
            case (ph)
                2'd0:    r[7:0]   = v[15:8];
                2'd1:    r[23:8]  = v;
                default: r[31:24] = v[7:0];
            endcase
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  phase_q, phase_d;
    logic [1:0]  nph_q, nph_d;
    logic        we_q, we_d;
    logic        size_q, size_d;
    logic [18:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [17:0] addr_r_q, addr_r_d;
    logic [17:0] addr_w_q, addr_w_d;
    logic [15:0] value_w_q, value_w_d;
    logic        lb_q, lb_d;
    logic        hb_q, hb_d;
`ifdef MEM_PORT_ALIGN_CHECK_EN
    logic        bad_q, bad_d;
    logic        err_q, err_d;
`endif

    logic        accept;
    logic        iss;
    logic [1:0]  iss_ph;
    logic [1:0]  nxt_ph;
    logic        more;
    logic        src_we;
    logic        src_size;
    logic [18:0] src_addr;
    logic [31:0] src_wdata;
    logic [17:0] ln;
    logic [17:0] hw;

    assign accept = (state_q == IDLE) && !busy_q && REQ;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        nph_d     = nph_q;
        we_d      = we_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rbuf_d    = rbuf_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;
        read_d    = read_q;
        write_d   = write_q;
        addr_r_d  = addr_r_q;
        addr_w_d  = addr_w_q;
        value_w_d = value_w_q;
        lb_d      = lb_q;
        hb_d      = hb_q;
`ifdef MEM_PORT_ALIGN_CHECK_EN
        bad_d     = bad_q;
        err_d     = 1'b0;
        more      = 1'b0;
`else
        more      = 1'b0;
`endif
        iss       = 1'b0;
        iss_ph    = 2'd0;
        nxt_ph    = phase_q + 2'd1;
        ln        = '0;
        hw        = '0;
        // The accept cycle drives phase 0 straight from the ports; later phases use the latch.
        src_we    = accept ? WE    : we_q;
        src_size  = accept ? SIZE  : size_q;
        src_addr  = accept ? ADDR  : addr_q;
        src_wdata = accept ? WDATA : wdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = WE;
                    size_d  = SIZE;
                    addr_d  = ADDR;
                    wdata_d = WDATA;
                    busy_d  = 1'b1;
                    phase_d = 2'd0;
                    cnt_d   = 4'd0;
                    rbuf_d  = '0;
                    nph_d   = SIZE ? (ADDR[0] ? 2'd3 : 2'd2) : 2'd1;
`ifdef MEM_PORT_ALIGN_CHECK_EN
                    if (SIZE && ADDR[0]) begin
                        bad_d   = 1'b1;
                        state_d = GAP;
                    end else begin
                        bad_d   = 1'b0;
                        state_d = ACCESS;
                        iss     = 1'b1;
                    end
`else
                    state_d = ACCESS;
                    iss     = 1'b1;
`endif
                end else if (busy_q) begin
                    busy_d = 1'b0;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    lb_d    = 1'b0;
                    hb_d    = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = GAP;
                    if (!we_q) rbuf_d = merge(rbuf_q, size_q, addr_q[0], phase_q, VALUE);
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            GAP: begin
`ifdef MEM_PORT_ALIGN_CHECK_EN
                more = !bad_q && (nxt_ph < nph_q);
`else
                more = nxt_ph < nph_q;
`endif
                if (more) begin
                    phase_d = nxt_ph;
                    state_d = ACCESS;
                    iss     = 1'b1;
                    iss_ph  = nxt_ph;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
`ifdef MEM_PORT_ALIGN_CHECK_EN
                    err_d = bad_q;
                    if (!we_q && !bad_q) rdata_d = rbuf_q;
`else
                    if (!we_q) rdata_d = rbuf_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (iss) begin
            ln = lanes(src_size, src_addr[0], iss_ph, src_wdata);
            hw = src_addr[18:1] + 18'(iss_ph);
            if (src_we) begin
                write_d   = 1'b1;
                addr_w_d  = hw;
                value_w_d = ln[15:0];
                lb_d      = ln[17];
                hb_d      = ln[16];
            end else begin
                read_d   = 1'b1;
                addr_r_d = hw;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            phase_q   <= '0;
            nph_q     <= '0;
            we_q      <= 1'b0;
            size_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rbuf_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            addr_r_q  <= '0;
            addr_w_q  <= '0;
            value_w_q <= '0;
            lb_q      <= 1'b0;
            hb_q      <= 1'b0;
`ifdef MEM_PORT_ALIGN_CHECK_EN
            bad_q     <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            nph_q     <= nph_d;
            we_q      <= we_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rbuf_q    <= rbuf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            read_q    <= read_d;
            write_q   <= write_d;
            addr_r_q  <= addr_r_d;
            addr_w_q  <= addr_w_d;
            value_w_q <= value_w_d;
            lb_q      <= lb_d;
            hb_q      <= hb_d;
`ifdef MEM_PORT_ALIGN_CHECK_EN
            bad_q     <= bad_d;
            err_q     <= err_d;
`endif
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign RDATA     = rdata_q;
    assign READ      = read_q;
    assign WRITE     = write_q;
    assign ADDRESS_R = addr_r_q;
    assign ADDRESS_W = addr_w_q;
    assign VALUE_W   = value_w_q;
    assign LB        = lb_q;
    assign HB        = hb_q;
`ifdef MEM_PORT_ALIGN_CHECK_EN
    assign ERR       = err_q;
`endif

endmodule

// File: tb/tb_y86_mem_port.sv
// Scoreboard bench for y86_mem_port: byte-level memory reference model versus an SRAM model.
module tb_y86_mem_port;
    localparam int ACC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        size = 1'b0;
    logic [18:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, read, write, lb, hb;
    logic [31:0] rdata;
    logic [17:0] addr_r, addr_w;
    logic [15:0] value_w;
    logic [15:0] value;

    logic [15:0] sram [0:262143];
    logic [7:0]  refb [0:524287];

    typedef struct {
        logic        we;
        logic        size;
        logic [18:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          acc_cyc;
        int          nph;
    } txn_t;
    txn_t sbq[$];

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    bit in_flight = 1'b0;

    int          ph_idx = 0;
    int          run_len = 0;
    logic [17:0] run_addr = '0;
    bit          prev_stb = 1'b0;

    y86_mem_port #(.ACC_CYCLES(ACC)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .REQ(req), .WE(we), .SIZE(size),
        .ADDR(addr), .WDATA(wdata), .BUSY(busy), .DONE(done), .RDATA(rdata),
        .READ(read), .WRITE(write), .ADDRESS_R(addr_r), .ADDRESS_W(addr_w),
        .VALUE_W(value_w), .LB(lb), .HB(hb), .VALUE(value)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;
    assign value = sram[addr_r];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [7:0] sb(input logic [18:0] a);
        return a[0] ? sram[a[18:1]][15:8] : sram[a[18:1]][7:0];
    endfunction

    task automatic set_hw(input logic [17:0] h, input logic [15:0] v);
        sram[h] = v;
        refb[{h, 1'b0}] = v[7:0];
        refb[{h, 1'b1}] = v[15:8];
    endtask

    // SRAM model plus protocol and scoreboard monitor.
    always @(negedge clk) begin
        logic [17:0] cur;
        if (!rst_n) begin
            prev_stb = 1'b0;
            run_len  = 0;
            ph_idx   = 0;
        end else begin
            if (read || write) begin
                chk("strobe_excl", {31'd0, read & write}, 32'd0);
                cur = read ? addr_r : addr_w;
                if (!prev_stb) begin
                    run_len  = 1;
                    run_addr = cur;
                    if (sbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL stray_strobe: got strobe at %h required none", cur);
                    end else begin
                        chk("phase_addr", {14'd0, cur}, {14'd0, 18'(sbq[0].addr[18:1] + 18'(ph_idx))});
                        chk("strobe_dir", {31'd0, write}, {31'd0, sbq[0].we});
                    end
                end else begin
                    run_len++;
                    chk("addr_stable", {14'd0, cur}, {14'd0, run_addr});
                end
                if (write) begin
                    if (lb) sram[addr_w][7:0]  = value_w[7:0];
                    if (hb) sram[addr_w][15:8] = value_w[15:8];
                end
            end else if (prev_stb) begin
                chk("strobe_len", run_len, ACC);
                ph_idx++;
            end
            prev_stb = read || write;

            if (done) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got DONE=1 required 0 (cycle %0d)", cycle);
                end else begin
                    txn_t t;
                    t = sbq.pop_front();
                    chk("latency", cycle - t.acc_cyc, t.nph * (ACC + 1));
                    chk("phase_count", ph_idx, t.nph);
                    chk("busy_in_done", {31'd0, busy}, 32'd1);
                    if (!t.we) begin
                        chk("rdata", rdata, t.exp);
                    end else begin
                        for (int i = -1; i <= (t.size ? 4 : 1); i++) begin
                            logic [18:0] ba;
                            ba = 19'(t.addr + 19'(i));
                            chk("store_byte", {24'd0, sb(ba)}, {24'd0, refb[ba]});
                        end
                    end
                end
                ph_idx = 0;
            end
        end
    end

    task automatic do_txn(input logic w, input logic s, input logic [18:0] a,
                          input logic [31:0] d, input bit early, input bit noise);
        txn_t t;
        int   n;
        bit   ok;
        ok = 1'b0;
        if (early) begin
            for (int k = 0; k < 100 && !ok; k++) begin
                @(negedge clk);
                if (done) ok = 1'b1;
            end
            if (!ok) chk("wait_done_timeout", 32'd0, 32'd1);
            we = w; size = s; addr = a; wdata = d; req = 1'b1;
            @(negedge clk);
            chk("busy_after_done", {31'd0, busy}, 32'd0);
        end else begin
            for (int k = 0; k < 100 && !ok; k++) begin
                @(negedge clk);
                if (!busy) ok = 1'b1;
            end
            if (!ok) chk("wait_idle_timeout", 32'd0, 32'd1);
            we = w; size = s; addr = a; wdata = d; req = 1'b1;
        end
        n = s ? 4 : 1;
        t.we = w; t.size = s; t.addr = a; t.wdata = d;
        t.nph = !s ? 1 : (a[0] ? 3 : 2);
        t.acc_cyc = cycle + 1;
        t.exp = '0;
        for (int i = 0; i < n; i++) begin
            logic [18:0] ba;
            ba = 19'(a + 19'(i));
            if (w) refb[ba] = d[8*i +: 8];
            else   t.exp[8*i +: 8] = refb[ba];
        end
        sbq.push_back(t);
        @(negedge clk);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        req = 1'b0; we = $urandom; size = $urandom; addr = 19'($urandom); wdata = $urandom;
        if (noise && t.nph >= 2) begin
            @(negedge clk);
            req = 1'b1;
            @(negedge clk);
            req = 1'b0;
        end
        in_flight = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0] ra;
        for (int i = 0; i < 262144; i++) set_hw(18'(i), 16'($urandom));

        repeat (3) @(negedge clk);
        chk("rst_read", {31'd0, read}, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_lanes", {30'd0, lb, hb}, 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addr", {addr_r[15:0], addr_w[15:0]}, 32'd0);
        chk("rst_addr_hi", {28'd0, addr_r[17:16], addr_w[17:16]}, 32'd0);
        chk("rst_value_w", {16'd0, value_w}, 32'd0);
        rst_n = 1'b1;

        set_hw(18'h00002, 16'hBEEF);
        do_txn(1'b0, 1'b0, 19'h00005, 32'h0, 1'b0, 1'b0);
        do_txn(1'b1, 1'b1, 19'h00010, 32'h11223344, 1'b0, 1'b0);
        set_hw(18'h00010, 16'hAA01);
        set_hw(18'h00011, 16'hCCBB);
        set_hw(18'h00012, 16'h55DD);
        do_txn(1'b0, 1'b1, 19'h00021, 32'h0, 1'b0, 1'b1);
        do_txn(1'b0, 1'b1, 19'h7FFFF, 32'h0, 1'b1, 1'b0);
        do_txn(1'b1, 1'b1, 19'h7FFFF, 32'hA1B2C3D4, 1'b0, 1'b1);
        do_txn(1'b0, 1'b1, 19'h7FFFF, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 150; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 19'(19'h7FFFC + 19'($urandom_range(0, 3)))
                                             : 19'($urandom_range(0, 511));
            do_txn($urandom_range(0, 1), $urandom_range(0, 1), ra, $urandom,
                   in_flight && ($urandom_range(0, 3) == 0), $urandom_range(0, 2) == 0);
        end

        // Reset during phase 1 of an aligned long store.
        ra = 19'h00040;
        do_txn(1'b1, 1'b1, ra, 32'hCAFEF00D, 1'b0, 1'b1);
        begin
            bit hit;
            hit = 1'b0;
            for (int k = 0; k < 50 && !hit; k++) begin
                @(negedge clk);
                if (write && ph_idx == 1) hit = 1'b1;
            end
            chk("reach_phase1", {31'd0, hit}, 32'd1);
        end
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_write", {31'd0, write}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        sbq.delete();
        in_flight = 1'b0;
        for (int i = -1; i <= 4; i++) refb[19'(ra + 19'(i))] = sb(19'(ra + 19'(i)));
        repeat (2) begin
            @(negedge clk);
            chk("no_done_in_reset", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_done_after_reset", {30'd0, done, busy}, 32'd0);
        end
        do_txn(1'b0, 1'b1, ra, 32'h0, 1'b0, 1'b0);
        do_txn(1'b0, 1'b0, 19'h00005, 32'h0, 1'b0, 1'b0);

        begin
            bit ok;
            ok = 1'b0;
            for (int k = 0; k < 100 && !ok; k++) begin
                @(negedge clk);
                if (!busy && sbq.size() == 0) ok = 1'b1;
            end
            chk("drain", {31'd0, ok}, 32'd1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
